// File: rtl/timer_dev.sv
`timescale 1ns/1ps
// timer_dev: memory-mapped countdown timer sitting in the data-memory address
// space. The core reads and writes four word registers through a 16-byte window.
// The timer raises a level interrupt request toward CP0.
//
// Ports:
//   clk    - system clock, all state changes on the rising edge
//   reset  - synchronous active-high reset
//   sel    - bus access strobe qualifying addr/we
//   addr   - byte address (offset = addr[3:2], addr[1:0] ignored)
//   we     - store enable
//   wdata  - store data
//   rdata  - load data, combinational, 0 when the window is not hit
//   irq    - interrupt request (IM & irq_flag)
//
// Register map: 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (read-only), 3 reserved.
module timer_dev #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic        hit_s;
    logic [1:0]  off_s;
    logic        wr_ctrl_s;
    logic        wr_preset_s;
    logic        unused_addr_s;

    assign hit_s         = sel & (addr[31:4] == BASE_ADDR[31:4]);
    assign off_s         = addr[3:2];
    assign wr_ctrl_s     = hit_s & we & (off_s == 2'd0);
    assign wr_preset_s   = hit_s & we & (off_s == 2'd1);
    assign unused_addr_s = ^addr[1:0];

    // Interrupt request is a pure function of registered state.
    assign irq = ctrl_q[3] & irq_flag_q;

    // Load data mux: selected register on a window hit, zero otherwise.
    always_comb begin
        rdata = 32'd0;
        if (hit_s) begin
            case (off_s)
                2'd0:    rdata = {28'd0, ctrl_q};
                2'd1:    rdata = preset_q;
                2'd2:    rdata = count_q;
                default: rdata = 32'd0;
            endcase
        end else begin
            rdata = 32'd0;
        end
    end

    // Next-state logic: a CTRL/PRESET store restarts the timer from IDLE and
    // takes priority over the FSM for that cycle.
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        if (wr_ctrl_s || wr_preset_s) begin
            if (wr_ctrl_s) begin
                ctrl_d = wdata[3:0];
            end else begin
                preset_d = wdata;
            end
            state_d    = S_IDLE;
            irq_flag_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ctrl_q[0]) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LOAD: begin
                    count_d = preset_q;
                    state_d = S_CNT;
                end
                S_CNT: begin
                    if (!ctrl_q[0]) begin
                        // Disabled mid-count: COUNT freezes where it is.
                        state_d = S_IDLE;
                    end else if (count_q == 32'd0) begin
                        state_d    = S_INT;
                        irq_flag_d = 1'b1;
                    end else begin
                        count_d = count_q - 32'd1;
                    end
                end
                S_INT: begin
                    state_d = S_IDLE;
                    if (ctrl_q[2:1] == 2'd1) begin
                        // Auto-reload: EN stays set so IDLE re-enters LOAD.
                        irq_flag_d = 1'b0;
                    end else begin
                        // One-shot (MODE 0, 2, 3): stop and keep the flag.
                        ctrl_d[0] = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset overriding all other activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

endmodule
